// File: rtl/arb_pkg.sv
// arb_pkg: shared sizes, index types and the 4-way round-robin pick used by bank_group_arbiter.
package arb_pkg;
    localparam int NUM_GROUPS      = 4;
    localparam int BANKS_PER_GROUP = 4;
    localparam int NUM_BANKS       = NUM_GROUPS * BANKS_PER_GROUP;

    typedef logic [1:0] grp_idx_t;
    typedef logic [1:0] bank_idx_t;

    // Returns {found, idx}; priority starts just after ptr and wraps, so ptr itself is last.
    function automatic logic [2:0] rr_pick4(input logic [3:0] req, input logic [1:0] ptr);
        logic [2:0] r;
        logic [1:0] k;
        r = '0;
        for (int i = 4; i >= 1; i--) begin
            k = ptr + 2'(i);
            if (req[k]) r = {1'b1, k};
        end
        return r;
    endfunction
endpackage

// File: rtl/rr_pick4.sv
// rr_pick4: combinational 4-way round-robin picker.
module rr_pick4 (
    input  logic [3:0] req_i,
    input  logic [1:0] ptr_i,
    output logic       found_o,
    output logic [1:0] idx_o
);
    assign {found_o, idx_o} = arb_pkg::rr_pick4(req_i, ptr_i);
endmodule

// File: rtl/bank_group_arbiter.sv
// bank_group_arbiter: picks one ready bank per issue slot with group/bank round-robin
// and DDR column-to-column spacing (TCCD_L same group, TCCD_S across groups).
module bank_group_arbiter
    import arb_pkg::*;
#(
    parameter int TCCD_L = 4,
    parameter int TCCD_S = 2,
    parameter int CNT_W  = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] req_valid,
    output logic [7:0]  bank_sel,
    output logic [1:0]  group_sel,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [15:0] bank_grant
);
    localparam logic [CNT_W:0] L_GAP = (CNT_W + 1)'(TCCD_L);
    localparam logic [CNT_W:0] S_GAP = (CNT_W + 1)'(TCCD_S);

    logic                 out_valid_q, out_valid_d;
    logic [7:0]           bank_sel_q, bank_sel_d;
    grp_idx_t             group_sel_q, group_sel_d;
    grp_idx_t             group_ptr_q, group_ptr_d;
    grp_idx_t             last_group_q, last_group_d;
    logic [7:0]           bank_ptr_q, bank_ptr_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d;

    logic                 acc, load, grp_found;
    bank_idx_t            cur_bank;
    grp_idx_t             grp_win;
    logic [NUM_BANKS-1:0] mask;
    logic [CNT_W:0]       gap;
    logic [3:0]           elig, bank_found;
    logic [7:0]           bank_idx;

    assign acc        = out_valid_q & out_ready;
    assign cur_bank   = bank_sel_q[2*group_sel_q +: 2];
    assign bank_grant = acc ? (16'd1 << {group_sel_q, cur_bank}) : '0;
    assign mask       = req_valid & ~bank_grant;
    assign gap        = acc ? (CNT_W + 1)'(1) : {1'b0, cnt_q} + 1'b1;
    assign load       = !out_valid_q || acc;

    // Pointers and last_group see the acceptance of this very cycle, so a
    // same-cycle reload already rotates past and spaces from the granted bank.
    assign group_ptr_d  = acc ? group_sel_q : group_ptr_q;
    assign last_group_d = acc ? group_sel_q : last_group_q;
    always_comb begin
        bank_ptr_d = bank_ptr_q;
        if (acc) bank_ptr_d[2*group_sel_q +: 2] = cur_bank;
    end

    for (genvar g = 0; g < NUM_GROUPS; g++) begin : g_bank
        rr_pick4 u_bank (
            .req_i  (mask[4*g +: 4]),
            .ptr_i  (bank_ptr_d[2*g +: 2]),
            .found_o(bank_found[g]),
            .idx_o  (bank_idx[2*g +: 2])
        );
        assign elig[g] = bank_found[g] &&
                         (gap >= ((grp_idx_t'(g) == last_group_d) ? L_GAP : S_GAP));
    end

    rr_pick4 u_grp (
        .req_i  (elig),
        .ptr_i  (group_ptr_d),
        .found_o(grp_found),
        .idx_o  (grp_win)
    );

    always_comb begin
        out_valid_d = load ? grp_found : out_valid_q;
        bank_sel_d  = bank_sel_q;
        group_sel_d = group_sel_q;
        if (load && grp_found) begin
            bank_sel_d[2*grp_win +: 2] = bank_idx[2*grp_win +: 2];
            group_sel_d                = grp_win;
        end
        cnt_d = acc ? CNT_W'(1) : (&cnt_q ? cnt_q : cnt_q + 1'b1);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q  <= 1'b0;
            bank_sel_q   <= '0;
            group_sel_q  <= '0;
            group_ptr_q  <= 2'd3;
            last_group_q <= '0;
            bank_ptr_q   <= 8'hFF;
            cnt_q        <= '1;
        end else begin
            out_valid_q  <= out_valid_d;
            bank_sel_q   <= bank_sel_d;
            group_sel_q  <= group_sel_d;
            group_ptr_q  <= group_ptr_d;
            last_group_q <= last_group_d;
            bank_ptr_q   <= bank_ptr_d;
            cnt_q        <= cnt_d;
        end
    end

    assign out_valid = out_valid_q;
    assign bank_sel  = bank_sel_q;
    assign group_sel = group_sel_q;
endmodule
